// File: rtl/z_core_div_ctrl_if.sv
// rtl/z_core_div_ctrl_if.sv - execute-stage request/response bundle for the divide controller
interface z_core_div_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;

    modport master (
        output req_valid, req_funct3, req_rs1, req_rs2, req_rd, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_rd
    );

    modport slave (
        input  req_valid, req_funct3, req_rs1, req_rs2, req_rd, resp_ready,
        output req_ready, resp_valid, resp_data, resp_rd
    );
endinterface

// File: rtl/z_core_div_ctrl.sv
// rtl/z_core_div_ctrl.sv - issue/response controller for RV32M DIV/DIVU/REM/REMU
module z_core_div_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    z_core_div_ctrl_if.slave     bus,
    input  logic                 flush,
    output logic                 busy,
    output logic                 err_timeout,
    output logic [CNT_W-1:0]     op_count,
    output logic                 du_start,
    output logic [31:0]          du_dividend,
    output logic [31:0]          du_divisor,
    output logic                 du_is_signed,
    output logic                 du_quotient_or_rem,
    input  logic                 du_done,
    input  logic [31:0]          du_result
);

    localparam int               WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        rs1_q, rs2_q, resp_data_q;
    logic [4:0]         rd_q;
    logic               is_signed_q, quot_q;
    logic [WD_W-1:0]    wdog_q;
    logic [CNT_W-1:0]   op_count_q;
    logic               err_timeout_q;

    logic               accept;
    logic               bypass;
    logic [31:0]        bypass_data;
    logic               wd_expire;
    logic               wd_at_limit;

    // A flush that lands on the last WAIT cycle leaves the counter past the
    // limit, so DRAIN must treat anything at or above it as expired.
    assign wd_at_limit = (wdog_q >= WD_LIMIT);

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        bypass      = 1'b0;
        bypass_data = '0;
        wd_expire   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && !flush) begin
                    accept = 1'b1;
                    if (bus.req_funct3[2]) begin
                        if (bus.req_rs2 == 32'h0) begin
                            bypass      = 1'b1;
                            bypass_data = bus.req_funct3[1] ? bus.req_rs1 : 32'hFFFF_FFFF;
                        end else if (!bus.req_funct3[0] && bus.req_rs1 == 32'h8000_0000 &&
                                     bus.req_rs2 == 32'hFFFF_FFFF) begin
                            bypass      = 1'b1;
                            bypass_data = bus.req_funct3[1] ? 32'h0 : 32'h8000_0000;
                        end
                        state_d = bypass ? S_RESP : S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                state_d = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = S_DRAIN;
                end else if (du_done) begin
                    state_d = S_RESP;
                end else if (wd_at_limit) begin
                    wd_expire = 1'b1;
                    state_d   = S_DRAIN;
                end
            end
            S_RESP: begin
                if (flush || bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (du_done) begin
                    state_d = S_IDLE;
                end else if (wd_at_limit) begin
                    wd_expire = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            is_signed_q   <= 1'b0;
            quot_q        <= 1'b0;
            resp_data_q   <= '0;
            wdog_q        <= '0;
            op_count_q    <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            err_timeout_q <= wd_expire;
            if (accept) begin
                rs1_q       <= bus.req_rs1;
                rs2_q       <= bus.req_rs2;
                rd_q        <= bus.req_rd;
                is_signed_q <= ~bus.req_funct3[0];
                quot_q      <= ~bus.req_funct3[1];
            end
            if (bypass) begin
                resp_data_q <= bypass_data;
            end else if (state_q == S_WAIT && du_done && !flush) begin
                resp_data_q <= du_result;
            end
            // Expiry restarts the window so DRAIN gets its own full budget.
            if (state_q == S_LAUNCH || wd_expire) begin
                wdog_q <= '0;
            end else if (state_q == S_WAIT || state_q == S_DRAIN) begin
                wdog_q <= wdog_q + 1'b1;
            end
            if (state_q == S_RESP && bus.resp_ready && !flush) begin
                op_count_q <= op_count_q + 1'b1;
            end
        end
    end

    assign bus.req_ready      = (state_q == S_IDLE);
    assign bus.resp_valid     = (state_q == S_RESP);
    assign bus.resp_data      = resp_data_q;
    assign bus.resp_rd        = rd_q;
    assign busy               = (state_q != S_IDLE);
    assign err_timeout        = err_timeout_q;
    assign op_count           = op_count_q;
    assign du_start           = (state_q == S_LAUNCH);
    assign du_dividend        = rs1_q;
    assign du_divisor         = rs2_q;
    assign du_is_signed       = is_signed_q;
    assign du_quotient_or_rem = quot_q;

endmodule

// File: tb/tb_z_core_div_ctrl.sv
// tb/tb_z_core_div_ctrl.sv - directed scoreboard bench for z_core_div_ctrl
module tb_z_core_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        busy;
    logic        err_timeout;
    logic [31:0] op_count;
    logic        du_start;
    logic [31:0] du_dividend;
    logic [31:0] du_divisor;
    logic        du_is_signed;
    logic        du_quotient_or_rem;
    logic        du_done;
    logic [31:0] du_result;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int starts = 0;
    int err_pulses = 0;

    bit          div_en = 1'b1;
    int          div_lat = 3;
    int          div_cnt = 0;
    logic [31:0] div_res;
    logic        last_signed;
    logic        last_qr;

    logic [36:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    z_core_div_ctrl_if bus ();

    z_core_div_ctrl #(
        .TIMEOUT_CYCLES (255),
        .CNT_W          (32)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .bus                (bus.slave),
        .flush              (flush),
        .busy               (busy),
        .err_timeout        (err_timeout),
        .op_count           (op_count),
        .du_start           (du_start),
        .du_dividend        (du_dividend),
        .du_divisor         (du_divisor),
        .du_is_signed       (du_is_signed),
        .du_quotient_or_rem (du_quotient_or_rem),
        .du_done            (du_done),
        .du_result          (du_result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural divider: answers a start pulse div_lat cycles later.
    always @(negedge clk) begin
        if (rst) begin
            du_done = 1'b0;
            div_cnt = 0;
        end else begin
            du_done = 1'b0;
            if (div_cnt > 0) begin
                div_cnt--;
                if (div_cnt == 0) begin
                    du_done   = 1'b1;
                    du_result = div_res;
                end
            end
            if (du_start) begin
                starts++;
                last_signed = du_is_signed;
                last_qr     = du_quotient_or_rem;
                if (div_en) begin
                    div_cnt = div_lat;
                    if (du_is_signed)
                        div_res = du_quotient_or_rem ? 32'($signed(du_dividend) / $signed(du_divisor))
                                                     : 32'($signed(du_dividend) % $signed(du_divisor));
                    else
                        div_res = du_quotient_or_rem ? du_dividend / du_divisor
                                                     : du_dividend % du_divisor;
                end
            end
        end
    end

    // Response scoreboard: pop on every accepted response.
    always @(negedge clk) begin
        logic [36:0] e;
        if (!rst) begin
            if (err_timeout) err_pulses++;
            if (bus.resp_valid && bus.resp_ready && !flush) begin
                check("resp_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("resp_data", bus.resp_data, e[31:0]);
                    check("resp_rd", 32'(bus.resp_rd), 32'(e[36:32]));
                end
            end
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit expect_resp, input logic [31:0] exp);
        int n = 0;
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_funct3 = f3;
        bus.req_rs1    = a;
        bus.req_rs2    = b;
        bus.req_rd     = rd;
        if (expect_resp) exp_q.push_back({rd, exp});
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_accepted", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (!(bus.req_ready && exp_q.size() == 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.req_ready && exp_q.size() == 0), 32'd1);
    endtask

    task automatic wait_start(input string tag, output int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!du_start && n < 10);
        t = cyc;
        check(tag, 32'(du_start), 32'd1);
    endtask

    initial begin
        int t0;
        int t1;
        int n;
        rst            = 1'b1;
        flush          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_rs1    = '0;
        bus.req_rs2    = '0;
        bus.req_rd     = '0;
        bus.resp_ready = 1'b1;
        du_done        = 1'b0;
        du_result      = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_count", op_count, 32'd0);
        check("rst_du_start", 32'(du_start), 32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);
        check("rst_resp_data", bus.resp_data, 32'd0);
        check("rst_du_dividend", du_dividend, 32'd0);

        // DIVU 100 / 7
        issue(3'b101, 32'd100, 32'd7, 5'd3, 1'b1, 32'd14);
        wait_idle("divu_idle", 50);
        check("divu_starts", 32'(starts), 32'd1);
        check("divu_signed", 32'(last_signed), 32'd0);
        check("divu_quot", 32'(last_qr), 32'd1);
        check("divu_count", op_count, 32'd1);

        // REM -7 % 2
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1, 32'hFFFF_FFFF);
        wait_idle("rem_idle", 50);
        check("rem_starts", 32'(starts), 32'd2);
        check("rem_signed", 32'(last_signed), 32'd1);
        check("rem_quot", 32'(last_qr), 32'd0);

        // Divide-by-zero and overflow bypasses
        issue(3'b100, 32'hFFFF_FFF9, 32'd0, 5'd7, 1'b1, 32'hFFFF_FFFF);
        check("div0_latency", 32'(bus.resp_valid), 32'd1);
        wait_idle("div0_idle", 20);
        issue(3'b111, 32'd5, 32'd0, 5'd8, 1'b1, 32'd5);
        check("remu0_latency", 32'(bus.resp_valid), 32'd1);
        wait_idle("remu0_idle", 20);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b1, 32'h8000_0000);
        check("ovf_div_latency", 32'(bus.resp_valid), 32'd1);
        wait_idle("ovf_div_idle", 20);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b1, 32'h0);
        wait_idle("ovf_rem_idle", 20);
        check("bypass_no_start", 32'(starts), 32'd2);
        check("bypass_count", op_count, 32'd6);

        // Illegal funct3 is dropped silently
        issue(3'b011, 32'd9, 32'd3, 5'd12, 1'b0, 32'd0);
        check("illegal_ready", 32'(bus.req_ready), 32'd1);
        check("illegal_busy", 32'(busy), 32'd0);

        // Back-pressured response held stable
        bus.resp_ready = 1'b0;
        issue(3'b101, 32'd10, 32'd3, 5'd9, 1'b1, 32'd3);
        n = 0;
        while (!bus.resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(bus.resp_valid), 32'd1);
            check("hold_data", bus.resp_data, 32'd3);
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
            check("hold_count", op_count, 32'd6);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        wait_idle("hold_idle", 20);
        check("hold_release_count", op_count, 32'd7);

        // Flush three cycles after the start pulse
        div_lat = 10;
        issue(3'b101, 32'd50, 32'd5, 5'd6, 1'b0, 32'd0);
        wait_start("flush_start", t0);
        repeat (3) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_drain_busy", 32'(busy), 32'd1);
        check("flush_no_resp", 32'(bus.resp_valid), 32'd0);
        wait_idle("flush_idle", 50);
        check("flush_count", op_count, 32'd7);
        check("flush_no_timeout", 32'(err_pulses), 32'd0);

        // Divider never answers: watchdog fires in WAIT and again in DRAIN
        div_en = 1'b0;
        issue(3'b101, 32'd1, 32'd1, 5'd4, 1'b0, 32'd0);
        wait_start("to_start", t0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!err_timeout && n < 400);
        check("to_first_delay", 32'(cyc - t0), 32'd256);
        t1 = cyc;
        @(negedge clk);
        check("to_pulse_width", 32'(err_timeout), 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!err_timeout && n < 400);
        check("to_second_delay", 32'(cyc - t1), 32'd255);
        @(negedge clk);
        check("to_req_ready", 32'(bus.req_ready), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_pulses", 32'(err_pulses), 32'd2);
        check("to_count", op_count, 32'd7);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/z_core_div_ctrl.md
Name: z_core_div_ctrl

Overview:
- Issue/response controller between the execute stage and the multi-cycle divider for RISC-V M-extension DIV/DIVU/REM/REMU.
- Accepts one request at a time and decodes funct3.
- Resolves divide-by-zero and signed overflow locally without launching the divider.
- Otherwise launches the divider and waits for its done pulse; then holds the result until the execute stage accepts it.
- Also handles pipeline flush and a divider watchdog.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT before the op is aborted with err_timeout.
- CNT_W, 32: width of the completed-operation counter.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept (state IDLE)
- req_funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; 0xx illegal
- req_rs1  in  32  dividend
- req_rs2  in  32  divisor
- req_rd  in  5  destination register tag
- flush  in  1  discard in-flight op
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  32  result
- resp_rd  out  5  tag of result
- busy  out  1  high whenever state != IDLE (execute-stage stall)
- err_timeout  out  1  one-cycle pulse on watchdog abort
- op_count  out  CNT_W  completed (accepted) responses, wraps
- du_start  out  1  one-cycle start pulse to divider
- du_dividend  out  32  held stable from start until done
- du_divisor  out  32  held stable from start until done
- du_is_signed  out  1  funct3[0]==0
- du_quotient_or_rem  out  1  funct3[1]==0
- du_done  in  1  divider completion pulse
- du_result  in  32  divider result, valid when du_done

Behaviour:
- Reset: state IDLE. All outputs 0 except req_ready=1. Latched operands, tag and op_count cleared. Reset mid-operation abandons the op; the divider is reset by the same source.
- States: IDLE, LAUNCH, WAIT, RESP, DRAIN.
- IDLE:
  - A handshake occurs when req_valid && req_ready && !flush. On handshake, latch rs1, rs2, rd and funct3.
  - funct3[2]==0 (illegal): request is ignored, with no response.
  - Bypass, rs2==0: quotient ops give 0xFFFFFFFF; remainder ops give rs1.
  - Bypass, signed op with rs1==0x80000000 and rs2==0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
  - Bypass goes to RESP next cycle, so resp_valid rises 1 cycle after the handshake.
  - Otherwise go to LAUNCH.
- LAUNCH: du_start=1 for exactly this cycle, with operands and flags driven from the latches. Next state is WAIT. The watchdog counter is cleared.
- WAIT:
  - du_start=0. The watchdog increments each cycle.
  - du_done: capture du_result into resp_data, go to RESP.
  - Watchdog reaches TIMEOUT_CYCLES without du_done: pulse err_timeout, go to DRAIN.
  - flush: go to DRAIN. This has priority over du_done in the same cycle.
- RESP:
  - resp_valid=1. resp_data and resp_rd are held constant until accepted.
  - resp_ready: op_count++, go to IDLE. resp_valid drops the next cycle.
  - flush: go to IDLE with no count, even if resp_ready is high in the same cycle.
- DRAIN:
  - Wait for du_done, discard the result, go to IDLE. No response is produced.
  - The watchdog keeps running; on expiry go to IDLE with a second err_timeout pulse.
  - Entered only when the divider was launched.
- No new request is accepted the cycle RESP/DRAIN exits; acceptance resumes in IDLE.
- flush in IDLE or LAUNCH:
  - IDLE: blocks the handshake.
  - LAUNCH: the start pulse is still issued, then the controller goes to DRAIN.
- du_done seen outside WAIT/DRAIN is ignored.
- Controller latency is 2 cycles on top of divider latency: handshake→LAUNCH, done→RESP.
- op_count wraps from all-ones to 0.

Test Plan:
- DIVU 100/7, resp_ready=1 → single du_start pulse, du_is_signed=0, du_quotient_or_rem=1; resp_data=14, resp_rd matches, op_count=1.
- REM rs1=0xFFFFFFF9 (-7), rs2=2 → divider launched signed/remainder; resp_data=0xFFFFFFFF (-1).
- DIV -7/0 and REMU 5/0 → no du_start; resp_valid 1 cycle after handshake, resp_data 0xFFFFFFFF and 5 respectively.
- DIV 0x80000000/0xFFFFFFFF → no du_start; resp_data 0x80000000. REM same operands → 0.
- DIVU 10/3, resp_ready=0 for 5 cycles after resp_valid → resp_data=3 held stable throughout; req_ready=0; one count after release.
- flush 3 cycles after du_start → DRAIN; after du_done, no resp_valid, req_ready returns.
- Stub du_done never asserted → err_timeout pulse after 255 WAIT cycles.
